depp_regbank: RTL
=================

# depp_regbank

Register-bank target for the DEPP bus controller. It consumes the controller's memory-side interface (write strobe, address, write data) and returns read data. It exposes to fabric logic a control byte, eight scratch bytes, a host-to-fabric byte FIFO, and a fabric-to-host mailbox with status flags. It sits directly downstream of the DEPP control state machine.

## Interface
- FIFO_AW, default 4: FIFO address width; depth = 2^FIFO_AW entries (range 2..7).
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- depp_mem_we  input  1  write strobe from DEPP controller; held high for a whole data-write cycle (multiple clocks).
- depp_mem_adr  input  8  register address.
- depp_mem_idata  input  8  write data; stable whenever depp_mem_we is high.
- depp_mem_odata  output  8  registered read data for depp_mem_adr.
- ctrl_out  output  8  contents of CTRL register.
- fifo_dout  output  8  head of FIFO (show-ahead).
- fifo_valid  output  1  FIFO not empty.
- fifo_ready  input  1  fabric pop; pop occurs when fifo_valid & fifo_ready.
- mbox_din  input  8  fabric-to-host data.
- mbox_valid  input  1  single-cycle capture strobe for mbox_din.
- irq  output  1  registered: mbox_full | fifo_overflow.

## Operation
- Write detect: we_q <= depp_mem_we; wr_stb = depp_mem_we & ~we_q. All register writes act only on wr_stb (exactly once per host write), using that cycle's adr/idata.
- Register map:
  - 0x00 CTRL: RW; drives ctrl_out.
  - 0x01 STATUS: RO; {3'b0, mbox_overrun, mbox_full, fifo_overflow, fifo_full, fifo_empty} (bit0 = empty).
  - 0x02 LEVEL: RO; FIFO count (FIFO_AW+1 bits), zero-extended.
  - 0x03 FIFO_DATA: WO push; reads 0x00.
  - 0x04 CMD: WO, reads 0x00. Bit0 flushes FIFO (pointers and count to 0). Bit1 clears fifo_overflow. Bit2 clears mbox_full and mbox_overrun.
  - 0x05 MBOX: RO; last captured mbox_din.
  - 0x08–0x0F SCRATCH0–7: RW.
  - All other addresses read 0x00; writes to them are ignored.
- FIFO push: wr_stb to 0x03 while not full stores the byte.
  - Push while full: byte dropped, fifo_overflow set (sticky).
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Pop while empty cannot occur, because fifo_valid = 0.
  - Push while empty: fifo_valid rises the next cycle.
  - Pointers wrap modulo 2^FIFO_AW.
  - Flush in the same cycle as a pop: flush wins.
- Mailbox: mbox_valid loads MBOX, sets mbox_full.
  - If mbox_full is already 1: data is overwritten with the newest byte and mbox_overrun is set.
  - Capture in the same cycle as a CMD bit2 clear: data = new byte, mbox_full = 1, mbox_overrun = 0.
  - CMD bit1 in the same cycle as an overflowing push: fifo_overflow ends at 1 (set wins).
- Read path: depp_mem_odata <= mux(depp_mem_adr) every clock, independent of we.

## Timing
- Reset values: ctrl_out 0x00, scratch 0x00, MBOX 0x00, depp_mem_odata 0x00, fifo_valid 0, irq 0, LEVEL 0, all flags 0, we_q 0.
  - FIFO storage contents are not reset; fifo_dout is don't-care while fifo_valid = 0.
- Write latency: register or flag updates at the clock edge ending the wr_stb cycle. ctrl_out changes 1 clock after depp_mem_we rises.
- Read latency: depp_mem_odata reflects address and state 1 clock after they change.
- Pop: fifo_dout and fifo_valid show the next entry 1 clock after the pop edge.
- irq lags flags by 1 clock.
- Reset asserted mid-transfer: everything returns to reset values immediately. If depp_mem_we is still high at release, we_q = 0 produces a wr_stb on the first clock after release; the controller also resets, so this is benign.

## Test plan
- Reset, then read 0x00–0x0F → odata 0x00 except STATUS = 0x01; irq = 0.
- Write 0xA5 to 0x00 with depp_mem_we held 5 clocks → ctrl_out = 0xA5 after 1 clock; SCRATCH unchanged; a single write effect (verify with 0x03: LEVEL = 1, not 5).
- FIFO_AW = 4: push 17 bytes 0x00..0x10 with fifo_ready = 0 → LEVEL = 16, STATUS = 0x06, irq = 1; pop all → bytes 0x00..0x0F in order, then STATUS = 0x05. CMD 0x02 → STATUS = 0x01.
- With FIFO full, push and pop in the same cycle → LEVEL stays 16, no overflow. Pointer wrap: 40 push/pop pairs preserve order.
- mbox_valid with 0x3C, then 0x4D → MBOX = 0x4D, STATUS bits 3 and 4 = 1. CMD 0x04 together with mbox_valid 0x5E → MBOX = 0x5E, bit3 = 1, bit4 = 0.
- CMD 0x01 with 3 entries queued and fifo_ready = 1 in the same cycle → LEVEL = 0, fifo_valid = 0 next clock.

Source files
------------

// File: rtl/depp_regbank_if.sv
// depp_regbank_if
//   Memory-side bus between the DEPP controller (master) and the register
//   bank (slave).
//   depp_mem_we     write strobe, held high for a whole host data-write cycle
//   depp_mem_adr    register address
//   depp_mem_idata  write data, stable while depp_mem_we is high
//   depp_mem_odata  registered read data for depp_mem_adr
interface depp_regbank_if;
   logic       depp_mem_we;
   logic [7:0] depp_mem_adr;
   logic [7:0] depp_mem_idata;
   logic [7:0] depp_mem_odata;

   modport master (
      output depp_mem_we,
      output depp_mem_adr,
      output depp_mem_idata,
      input  depp_mem_odata
   );

   modport slave (
      input  depp_mem_we,
      input  depp_mem_adr,
      input  depp_mem_idata,
      output depp_mem_odata
   );
endinterface

// File: rtl/depp_regbank.sv
// depp_regbank
//   Register bank behind the DEPP controller. Provides a control byte, eight
//   scratch bytes, a host-to-fabric byte FIFO and a fabric-to-host mailbox.
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   bus         DEPP memory-side bus (slave side)
//   ctrl_out    CTRL register contents
//   fifo_dout   FIFO head (show-ahead), valid while fifo_valid
//   fifo_valid  FIFO not empty
//   fifo_ready  fabric pop request
//   mbox_din    fabric-to-host byte
//   mbox_valid  single-cycle capture strobe for mbox_din
//   irq         registered mbox_full | fifo_overflow
module depp_regbank #(
   parameter int unsigned FIFO_AW = 4
) (
   input  logic               clk,
   input  logic               rst,
   depp_regbank_if.slave      bus,
   output logic [7:0]         ctrl_out,
   output logic [7:0]         fifo_dout,
   output logic               fifo_valid,
   input  logic               fifo_ready,
   input  logic [7:0]         mbox_din,
   input  logic               mbox_valid,
   output logic               irq
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
   localparam logic [FIFO_AW:0]   CNT_ONE = {{FIFO_AW{1'b0}}, 1'b1};

   logic               we_q;
   logic [7:0]         ctrl_q;
   logic [7:0]         scratch_q [8];
   logic [7:0]         mbox_q;
   logic               mbox_full_q;
   logic               mbox_ovr_q;
   logic               fifo_ovf_q;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   cnt_q, cnt_d;
   logic [7:0]         mem_q [DEPTH];
   logic [7:0]         odata_q, odata_d;
   logic               irq_q;

   logic wr_stb;
   logic fifo_full, fifo_empty;
   logic push_req, push_do, pop, flush;
   logic ovf_set, ovf_clr, mbox_clr;

   // One host write keeps we high for several clocks; act only on its rising edge.
   assign wr_stb     = bus.depp_mem_we & ~we_q;

   // Count never exceeds DEPTH, so its MSB alone marks full.
   assign fifo_full  = cnt_q[FIFO_AW];
   assign fifo_empty = (cnt_q == '0);

   assign push_req = wr_stb && (bus.depp_mem_adr == 8'h03);
   assign pop      = ~fifo_empty & fifo_ready;
   assign flush    = wr_stb && (bus.depp_mem_adr == 8'h04) && bus.depp_mem_idata[0];
   assign ovf_clr  = wr_stb && (bus.depp_mem_adr == 8'h04) && bus.depp_mem_idata[1];
   assign mbox_clr = wr_stb && (bus.depp_mem_adr == 8'h04) && bus.depp_mem_idata[2];

   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign push_do  = push_req & (~fifo_full | pop);
   assign ovf_set  = push_req & fifo_full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_do) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push_do && !pop)      cnt_d = cnt_q + CNT_ONE;
         else if (pop && !push_do) cnt_d = cnt_q - CNT_ONE;
      end
   end

   always_comb begin
      odata_d = '0;
      case (bus.depp_mem_adr)
         8'h00: odata_d = ctrl_q;
         8'h01: odata_d = {3'b000, mbox_ovr_q, mbox_full_q, fifo_ovf_q, fifo_full, fifo_empty};
         8'h02: odata_d = 8'(cnt_q);
         8'h05: odata_d = mbox_q;
         default: begin
            if (bus.depp_mem_adr[7:3] == 5'b00001)
               odata_d = scratch_q[bus.depp_mem_adr[2:0]];
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q        <= 1'b0;
         ctrl_q      <= '0;
         for (int unsigned i = 0; i < 8; i++) scratch_q[i] <= '0;
         mbox_q      <= '0;
         mbox_full_q <= 1'b0;
         mbox_ovr_q  <= 1'b0;
         fifo_ovf_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         odata_q     <= '0;
         irq_q       <= 1'b0;
      end else begin
         we_q     <= bus.depp_mem_we;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         odata_q  <= odata_d;
         irq_q    <= mbox_full_q | fifo_ovf_q;

         if (wr_stb && bus.depp_mem_adr == 8'h00)
            ctrl_q <= bus.depp_mem_idata;
         if (wr_stb && bus.depp_mem_adr[7:3] == 5'b00001)
            scratch_q[bus.depp_mem_adr[2:0]] <= bus.depp_mem_idata;

         if (ovf_set)      fifo_ovf_q <= 1'b1;
         else if (ovf_clr) fifo_ovf_q <= 1'b0;

         // Capture beats a same-cycle clear: data and full come from the new
         // byte, while overrun is cleared rather than set.
         if (mbox_valid) begin
            mbox_q      <= mbox_din;
            mbox_full_q <= 1'b1;
            mbox_ovr_q  <= mbox_clr ? 1'b0 : (mbox_ovr_q | mbox_full_q);
         end else if (mbox_clr) begin
            mbox_full_q <= 1'b0;
            mbox_ovr_q  <= 1'b0;
         end
      end
   end

   // FIFO storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (push_do) mem_q[wr_ptr_q] <= bus.depp_mem_idata;
   end

   assign fifo_dout          = mem_q[rd_ptr_q];
   assign fifo_valid         = ~fifo_empty;
   assign ctrl_out           = ctrl_q;
   assign irq                = irq_q;
   assign bus.depp_mem_odata = odata_q;

endmodule
